// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default
// geometry, the buffered write entry, and the round-robin grant rule.
package regfile_wb_arbiter_pkg;

  localparam int unsigned AW_DEF    = 4;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 2;

  // One buffered register write.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  // Which requester received the most recent grant.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } rr_last_e;

  // Returns {grant_b, grant_a}. A lone non-empty side always wins; on a
  // tie the side that was not granted last wins.
  function automatic logic [1:0] rr_grant(input logic a_ne, input logic b_ne,
                                          input rr_last_e last);
    logic ga;
    logic gb;
    ga = a_ne && (!b_ne || (last == LAST_B));
    gb = b_ne && !ga;
    return {gb, ga};
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding pending register writes for one requester.
// Besides the head entry it exposes every slot's valid flag and address so
// the owner can tell which registers still have writes in flight.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DEPTH-1:0]         slot_vld_o,
  output logic [DEPTH-1:0][AW-1:0] slot_addr_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // With a per-slot valid bit, "full" means the next write slot is still
  // occupied and "empty" means the read slot is vacant; DEPTH is a power of
  // two so the pointers wrap on their own.
  assign full_o     = vld_q[wr_ptr_q];
  assign empty_o    = ~vld_q[rd_ptr_q];
  assign head_o     = mem_q[rd_ptr_q];
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign slot_vld_o = vld_q;

  // Publish each slot's destination register for pending-write tracking.
  always_comb begin
    slot_addr_o = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      slot_addr_o[j] = mem_q[j].addr;
    end
  end

  // Occupancy and pointers; reset discards everything still buffered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Entry storage is data only and is never cleared; slot valids gate it.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and load (B) writebacks into the single register-file
// write port. Each side is buffered in its own FIFO; one head is popped per
// cycle, round-robin on ties, and registered onto wr_*. Writes to register 0
// are drained but never strobed. busy_mask flags registers with a write
// still buffered or sitting on the output stage.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [2**AW-1:0]  busy_mask
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t                   a_push_data;
  entry_t                   b_push_data;
  entry_t                   a_head;
  entry_t                   b_head;
  entry_t                   sel;
  logic                     a_full;
  logic                     a_empty;
  logic                     b_full;
  logic                     b_empty;
  logic                     a_push;
  logic                     b_push;
  logic [1:0]               grant;
  logic                     pop_a;
  logic                     pop_b;
  logic [DEPTH-1:0]         a_slot_vld;
  logic [DEPTH-1:0]         b_slot_vld;
  logic [DEPTH-1:0][AW-1:0] a_slot_addr;
  logic [DEPTH-1:0][AW-1:0] b_slot_addr;
  logic [2**AW-1:0]         busy_vec;

  rr_last_e                 last_q;
  rr_last_e                 last_d;
  logic                     wr_en_q;
  logic                     wr_en_d;
  logic [AW-1:0]            wr_addr_q;
  logic [AW-1:0]            wr_addr_d;
  logic [DW-1:0]            wr_data_q;
  logic [DW-1:0]            wr_data_d;

  // Ready reflects only fullness: a pop in the same cycle does not free a
  // slot for the incoming request until the next cycle.
  assign a_ready     = reset & ~a_full;
  assign b_ready     = reset & ~b_full;
  assign a_push      = a_valid & a_ready;
  assign b_push      = b_valid & b_ready;
  assign a_push_data = '{addr: a_addr, data: a_data};
  assign b_push_data = '{addr: b_addr, data: b_data};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .entry_t (entry_t)
  ) u_fifo_a (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (a_push),
    .push_data_i (a_push_data),
    .pop_i       (pop_a),
    .head_o      (a_head),
    .full_o      (a_full),
    .empty_o     (a_empty),
    .slot_vld_o  (a_slot_vld),
    .slot_addr_o (a_slot_addr)
  );

  wb_fifo #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .entry_t (entry_t)
  ) u_fifo_b (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (b_push),
    .push_data_i (b_push_data),
    .pop_i       (pop_b),
    .head_o      (b_head),
    .full_o      (b_full),
    .empty_o     (b_empty),
    .slot_vld_o  (b_slot_vld),
    .slot_addr_o (b_slot_addr)
  );

  // Pick at most one head and form the next output-stage contents.
  always_comb begin
    grant     = rr_grant(~a_empty, ~b_empty, last_q);
    pop_a     = grant[0];
    pop_b     = grant[1];
    sel       = pop_b ? b_head : a_head;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    if (pop_a || pop_b) begin
      wr_en_d   = (sel.addr != '0);
      wr_addr_d = sel.addr;
      wr_data_d = sel.data;
      last_d    = pop_b ? LAST_B : LAST_A;
    end
  end

  // Output stage and round-robin history; reset leaves A winning the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= LAST_B;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
    end
  end

  // A register is busy while any buffered entry or the strobed output stage
  // targets it; register 0 is never reported.
  always_comb begin
    busy_vec = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (a_slot_vld[j]) busy_vec[a_slot_addr[j]] = 1'b1;
      if (b_slot_vld[j]) busy_vec[b_slot_addr[j]] = 1'b1;
    end
    if (wr_en_q) busy_vec[wr_addr_q] = 1'b1;
    busy_vec[0] = 1'b0;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy_mask = busy_vec;

endmodule
